gen_job_scheduler: RTL and testbench
====================================

// Module: gen_job_scheduler
// PURPOSE
//   Shares the single nonogram-generator worker between NUM_REQ requesters (UI, loader, test hooks).
//   Round-robin arbitration; issues a one-cycle start pulse to the worker; waits for its done.
//   Captures the worker's pixel result and returns a per-requester completion ack.
//   Sits between the top-level control FSMs and the generator worker.
// PARAMETERS
//   NUM_REQ        4      number of requesters (2..8)
//   PIX_W          12     width of worker pixel result
//   TIMEOUT_CYCLES 65536  BUSY cycles allowed before abort (only with GEN_SCHED_TIMEOUT_EN)
// PORTS
//   clk_in            in   1        system clock
//   reset_n_in        in   1        synchronous reset, active-low
//   req_in            in   NUM_REQ  level request per requester; held until its ack
//   grant_out         out  NUM_REQ  one-hot owner of the current job; 0 in IDLE
//   ack_out           out  NUM_REQ  one-cycle completion pulse to the owner
//   busy_out          out  1        high in every state except IDLE
//   worker_start_out  out  1        one-cycle start pulse to worker
//   worker_abort_out  out  1        one-cycle abort pulse to worker (timeout only)
//   worker_done_in    in   1        worker completion strobe
//   worker_pixel_in   in   PIX_W    worker result; valid with worker_done_in
//   result_out        out  PIX_W    captured result; held until the next capture
//   result_valid_out  out  1        one-cycle pulse, coincident with ack_out
//   timeout_out       out  1        one-cycle pulse, coincident with ack_out on abort
//   job_count_out     out  16       completed jobs (ok + timeout); wraps 0xFFFF->0
// BEHAVIOUR
//   - Reset (reset_n_in=0 at an edge): state=IDLE, rr_ptr=0, all outputs 0, timer=0. Overrides mid-job.
//     No start/abort is issued on reset.
//   - States: IDLE -> START -> BUSY -> DONE -> IDLE; BUSY -> TOUT -> IDLE.
//   - IDLE: at an edge with req_in!=0, pick the first set bit searching from rr_ptr upward (wrapping).
//     Latch the one-hot grant; go to START.
//   - START (1 cycle): worker_start_out=1, grant_out valid, timer cleared; go to BUSY.
//     worker_done_in is ignored in START.
//   - BUSY: grant_out held; timer increments each cycle. On worker_done_in=1 at an edge:
//     result_out<=worker_pixel_in; go to DONE.
//   - DONE (1 cycle): ack_out=grant, result_valid_out=1, job_count+1, rr_ptr=granted index+1 (mod NUM_REQ).
//     grant_out stays valid this cycle; then IDLE.
//   - Latency: req sampled at edge t -> worker_start_out high in cycle t+1.
//     Done sampled at edge d -> ack in cycle d+1. Minimum gap: one IDLE cycle between ack and the next start.
//   - Requester dropping req_in mid-job does not abort; the ack is still issued.
//   - worker_done_in outside BUSY is ignored (no capture, no count).
//   - Simultaneous requests: strict round robin; a requester is served at most once per NUM_REQ jobs
//     while others wait.
//   - All outputs registered; grant/ack are one-hot or zero at all times.
// CONFIGURATION
//   GEN_SCHED_TIMEOUT_EN defined:
//     - In BUSY with timer==TIMEOUT_CYCLES-1 and no done: go to TOUT.
//     - TOUT (1 cycle): worker_abort_out=1, ack_out=grant, timeout_out=1, result_valid_out=0,
//       result_out unchanged, job_count+1, rr_ptr advanced; then IDLE.
//     - Done and timeout on the same edge: done wins.
//   GEN_SCHED_TIMEOUT_EN undefined:
//     - BUSY waits indefinitely; worker_abort_out and timeout_out tied 0; no timer logic.
// TESTING
//   - req_in=4'b0010, worker done 50000 cycles after start with pixel 12'h1FF
//     -> one start pulse; grant=0010; ack=0010 one cycle after done; result_out=12'h1FF; job_count=1.
//   - req_in=4'b1111 held, worker done 10 cycles after each start
//     -> grants in order 0001,0010,0100,1000,0001; never two grants at once.
//   - Reset asserted mid-BUSY -> next cycle all outputs 0, state IDLE.
//     A later done is ignored; the next req gets grant 0001 (rr_ptr=0).
//   - Spurious worker_done_in in IDLE and in START -> no ack, no result_valid, job_count unchanged.
//   - Timeout build with TIMEOUT_CYCLES=100, worker never done
//     -> abort, timeout_out and ack pulse 100 cycles after entering BUSY; result_out unchanged.
//   - Timeout build with done on the timeout edge -> normal DONE path, timeout_out=0.

Source files
------------

// File: rtl/gen_job_scheduler_if.sv
// Request/worker bus of the generator job scheduler: requester handshake, worker strobes, results.
// master drives requests and worker completions; slave is the scheduler itself.
interface gen_job_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int PIX_W   = 12
);
    logic [NUM_REQ-1:0] req_in;
    logic [NUM_REQ-1:0] grant_out;
    logic [NUM_REQ-1:0] ack_out;
    logic               busy_out;
    logic               worker_start_out;
    logic               worker_abort_out;
    logic               worker_done_in;
    logic [PIX_W-1:0]   worker_pixel_in;
    logic [PIX_W-1:0]   result_out;
    logic               result_valid_out;
    logic               timeout_out;
    logic [15:0]        job_count_out;

    modport master (
        output req_in, worker_done_in, worker_pixel_in,
        input  grant_out, ack_out, busy_out, worker_start_out, worker_abort_out,
        input  result_out, result_valid_out, timeout_out, job_count_out
    );

    modport slave (
        input  req_in, worker_done_in, worker_pixel_in,
        output grant_out, ack_out, busy_out, worker_start_out, worker_abort_out,
        output result_out, result_valid_out, timeout_out, job_count_out
    );
endinterface

// File: rtl/gen_job_scheduler.sv
// Round-robin sharing of the single nonogram generator worker; start pulse, wait for done, ack owner.
// Optional watchdog abort of a stuck worker when GEN_SCHED_TIMEOUT_EN is defined.
module gen_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int PIX_W          = 12,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    gen_job_scheduler_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("gen_job_scheduler: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_BUSY, S_DONE, S_TOUT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, idx_q, idx_d, pick_idx;
    logic               pick_vld;
    logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
    logic               busy_q, busy_d, start_q, start_d, rv_q, rv_d;
    logic [PIX_W-1:0]   result_q, result_d;
    logic [15:0]        count_q, count_d;

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && bus.req_in[rr_index(rr_ptr_q, i)]) begin
                pick_vld = 1'b1;
                pick_idx = rr_index(rr_ptr_q, i);
            end
        end
    end

`ifdef GEN_SCHED_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               abort_q, abort_d, tout_q, tout_d;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        grant_d  = grant_q;
        ack_d    = '0;
        start_d  = 1'b0;
        rv_d     = 1'b0;
        result_d = result_q;
        count_d  = count_q;
`ifdef GEN_SCHED_TIMEOUT_EN
        timer_d  = timer_q;
        abort_d  = 1'b0;
        tout_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_START;
                    idx_d   = pick_idx;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    start_d = 1'b1;
                end
            end
            S_START: begin
                state_d = S_BUSY;
`ifdef GEN_SCHED_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            S_BUSY: begin
`ifdef GEN_SCHED_TIMEOUT_EN
                timer_d = timer_q + TIMER_W'(1);
`endif
                // A done on the watchdog edge still completes normally.
                if (bus.worker_done_in) begin
                    state_d  = S_DONE;
                    result_d = bus.worker_pixel_in;
                    ack_d    = grant_q;
                    rv_d     = 1'b1;
                    count_d  = count_q + 16'd1;
                    rr_ptr_d = rr_index(idx_q, 1);
                end
`ifdef GEN_SCHED_TIMEOUT_EN
                else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = S_TOUT;
                    ack_d    = grant_q;
                    abort_d  = 1'b1;
                    tout_d   = 1'b1;
                    count_d  = count_q + 16'd1;
                    rr_ptr_d = rr_index(idx_q, 1);
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            rv_q     <= 1'b0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            rv_q     <= rv_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

`ifdef GEN_SCHED_TIMEOUT_EN
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            timer_q <= '0;
            abort_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            abort_q <= abort_d;
            tout_q  <= tout_d;
        end
    end
    assign bus.worker_abort_out = abort_q;
    assign bus.timeout_out      = tout_q;
`else
    assign bus.worker_abort_out = 1'b0;
    assign bus.timeout_out      = 1'b0;
`endif

    assign bus.grant_out        = grant_q;
    assign bus.ack_out          = ack_q;
    assign bus.busy_out         = busy_q;
    assign bus.worker_start_out = start_q;
    assign bus.result_out       = result_q;
    assign bus.result_valid_out = rv_q;
    assign bus.job_count_out    = count_q;
endmodule

// File: tb/tb_gen_job_scheduler.sv
// Directed bench for gen_job_scheduler: reset, long job, spurious dones, mid-job reset, round robin, watchdog.
module tb_gen_job_scheduler;
`ifdef GEN_SCHED_TIMEOUT_EN
    localparam int TOUT_CYC = 100;
    localparam int LONG_JOB = 50;
`else
    localparam int TOUT_CYC = 65536;
    localparam int LONG_JOB = 50000;
`endif

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mon_starts = 0, mon_aborts = 0, mon_touts = 0, mon_multi = 0;

    gen_job_scheduler_if #(.NUM_REQ(4), .PIX_W(12)) bus ();

    gen_job_scheduler #(.NUM_REQ(4), .PIX_W(12), .TIMEOUT_CYCLES(TOUT_CYC)) dut (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (bus.worker_start_out === 1'b1) mon_starts++;
        if (bus.worker_abort_out === 1'b1) mon_aborts++;
        if (bus.timeout_out === 1'b1)      mon_touts++;
        if ((bus.grant_out & (bus.grant_out - 4'd1)) != 4'd0 ||
            (bus.ack_out & (bus.ack_out - 4'd1)) != 4'd0) mon_multi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (bus.worker_start_out !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("start_seen", {31'd0, bus.worker_start_out}, 32'd1);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_grant"}, {28'd0, bus.grant_out}, 32'd0);
        check({tag, "_ack"},   {28'd0, bus.ack_out}, 32'd0);
        check({tag, "_busy"},  {31'd0, bus.busy_out}, 32'd0);
        check({tag, "_start"}, {31'd0, bus.worker_start_out}, 32'd0);
        check({tag, "_rv"},    {31'd0, bus.result_valid_out}, 32'd0);
        check({tag, "_res"},   {20'd0, bus.result_out}, 32'd0);
        check({tag, "_cnt"},   {16'd0, bus.job_count_out}, 32'd0);
    endtask

    logic [3:0] exp_g [5];
    int         n;

    initial begin
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b0;
        bus.req_in = '0;
        bus.worker_done_in = 1'b0;
        bus.worker_pixel_in = '0;
        repeat (3) step();
        check_idle_zero("reset");
        rst_n = 1'b1;
        step();

        // Spurious done while idle
        bus.worker_done_in = 1'b1;
        bus.worker_pixel_in = 12'hABC;
        repeat (2) step();
        bus.worker_done_in = 1'b0;
        step();
        check_idle_zero("idle_done");

        // Single long job from requester 1, with a spurious done during START
        bus.req_in = 4'b0010;
        step();
        check("a_start", {31'd0, bus.worker_start_out}, 32'd1);
        check("a_grant", {28'd0, bus.grant_out}, 32'h2);
        bus.worker_done_in = 1'b1;
        bus.worker_pixel_in = 12'hABC;
        step();
        bus.worker_done_in = 1'b0;
        check("a_start_drop", {31'd0, bus.worker_start_out}, 32'd0);
        check("a_busy", {31'd0, bus.busy_out}, 32'd1);
        check("a_start_done_ign", {31'd0, bus.result_valid_out}, 32'd0);
        repeat (LONG_JOB - 2) step();
        check("a_grant_held", {28'd0, bus.grant_out}, 32'h2);
        check("a_no_ack_yet", {28'd0, bus.ack_out}, 32'd0);
        bus.worker_done_in = 1'b1;
        bus.worker_pixel_in = 12'h1FF;
        step();
        bus.worker_done_in = 1'b0;
        bus.req_in = '0;
        check("a_ack", {28'd0, bus.ack_out}, 32'h2);
        check("a_rv", {31'd0, bus.result_valid_out}, 32'd1);
        check("a_result", {20'd0, bus.result_out}, 32'h1FF);
        check("a_count", {16'd0, bus.job_count_out}, 32'd1);
        check("a_grant_done", {28'd0, bus.grant_out}, 32'h2);
        step();
        check("a_ack_pulse", {28'd0, bus.ack_out}, 32'd0);
        check("a_grant_idle", {28'd0, bus.grant_out}, 32'd0);
        check("a_busy_idle", {31'd0, bus.busy_out}, 32'd0);
        check("a_result_hold", {20'd0, bus.result_out}, 32'h1FF);
        check("a_one_start", mon_starts, 32'd1);

        // Reset in the middle of a job
        bus.req_in = 4'b0001;
        repeat (2) step();
        bus.req_in = '0;
        repeat (3) step();
        check("c_busy_pre", {31'd0, bus.busy_out}, 32'd1);
        rst_n = 1'b0;
        step();
        check_idle_zero("c_reset");
        rst_n = 1'b1;
        step();
        bus.worker_done_in = 1'b1;
        step();
        bus.worker_done_in = 1'b0;
        step();
        check_idle_zero("c_late_done");

        // Round robin with all requesters held
        bus.req_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start(n);
            check($sformatf("rr_grant%0d", k), {28'd0, bus.grant_out}, {28'd0, exp_g[k]});
            if (k > 0) check($sformatf("rr_gap%0d", k), n, 32'd2);
            repeat (9) step();
            bus.worker_done_in = 1'b1;
            bus.worker_pixel_in = 12'h100 + 12'(k);
            step();
            bus.worker_done_in = 1'b0;
            check($sformatf("rr_ack%0d", k), {28'd0, bus.ack_out}, {28'd0, exp_g[k]});
            check($sformatf("rr_rv%0d", k), {31'd0, bus.result_valid_out}, 32'd1);
        end
        bus.req_in = '0;
        repeat (2) step();
        check("rr_count", {16'd0, bus.job_count_out}, 32'd5);
        check("rr_result", {20'd0, bus.result_out}, 32'h104);

`ifdef GEN_SCHED_TIMEOUT_EN
        // Worker never finishes
        bus.req_in = 4'b0001;
        wait_start(n);
        bus.req_in = '0;
        n = 0;
        while (bus.worker_abort_out !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("t_abort_cycles", n, 32'd101);
        check("t_ack", {28'd0, bus.ack_out}, 32'h1);
        check("t_tout", {31'd0, bus.timeout_out}, 32'd1);
        check("t_rv", {31'd0, bus.result_valid_out}, 32'd0);
        check("t_result", {20'd0, bus.result_out}, 32'h104);
        check("t_count", {16'd0, bus.job_count_out}, 32'd6);
        step();
        check("t_abort_pulse", {31'd0, bus.worker_abort_out}, 32'd0);

        // Done on the very edge the watchdog would fire
        bus.req_in = 4'b0010;
        wait_start(n);
        bus.req_in = '0;
        repeat (100) step();
        bus.worker_done_in = 1'b1;
        bus.worker_pixel_in = 12'h2A5;
        step();
        bus.worker_done_in = 1'b0;
        check("e_ack", {28'd0, bus.ack_out}, 32'h2);
        check("e_rv", {31'd0, bus.result_valid_out}, 32'd1);
        check("e_tout", {31'd0, bus.timeout_out}, 32'd0);
        check("e_result", {20'd0, bus.result_out}, 32'h2A5);
        check("e_count", {16'd0, bus.job_count_out}, 32'd7);
        repeat (2) step();
        check("total_starts", mon_starts, 32'd9);
        check("total_aborts", mon_aborts, 32'd1);
        check("total_touts", mon_touts, 32'd1);
`else
        check("total_starts", mon_starts, 32'd7);
        check("total_aborts", mon_aborts, 32'd0);
        check("total_touts", mon_touts, 32'd0);
`endif
        check("onehot", mon_multi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
